// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } ctrl_state_t;

    typedef logic [4:0] regbits_t;

    localparam int DEFAULT_DMEM_TIMEOUT = 1024;
    localparam int DEFAULT_CNT_W        = 16;

    // One control word per cycle; flushes override enables inside the latches.
    typedef struct packed {
        logic pc_en;
        logic en_ifid;
        logic en_idex;
        logic en_exmem;
        logic en_memwb;
        logic fl_ifid;
        logic fl_idex;
        logic fl_exmem;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE   = 8'b0_0000_000;
    localparam ctrl_t CTRL_GO     = 8'b1_1111_000;
    localparam ctrl_t CTRL_BRANCH = 8'b1_1111_111;
    localparam ctrl_t CTRL_LUSE   = 8'b0_0111_010;
    localparam ctrl_t CTRL_IMISS  = 8'b0_1111_100;
    localparam ctrl_t CTRL_HALT   = 8'b0_0001_111;

endpackage

// File: rtl/pipeline_controller_if.sv
// Bundle of pipeline status inputs and latch/PC control outputs of the controller.
interface pipeline_controller_if
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
);
    logic             ihit;
    logic             dhit;
    logic             dmemREN_MEM;
    logic             dmemWEN_MEM;
    logic             memtoReg_EX;
    regbits_t         rt_EX;
    regbits_t         rs_ID;
    regbits_t         rt_ID;
    logic             uses_rt_ID;
    logic             branch_taken_MEM;
    logic             halt_MEM;

    logic             pc_en;
    logic             enable_ifid;
    logic             enable_idex;
    logic             enable_exmem;
    logic             enable_memwb;
    logic             flush_ifid;
    logic             flush_idex;
    logic             flush_exmem;
    logic             halt;
    logic             timeout_err;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    modport master (
        input  ihit, dhit, dmemREN_MEM, dmemWEN_MEM, memtoReg_EX, rt_EX, rs_ID, rt_ID,
               uses_rt_ID, branch_taken_MEM, halt_MEM,
        output pc_en, enable_ifid, enable_idex, enable_exmem, enable_memwb,
               flush_ifid, flush_idex, flush_exmem, halt, timeout_err,
               stall_cycles, flush_events
    );

    modport slave (
        output ihit, dhit, dmemREN_MEM, dmemWEN_MEM, memtoReg_EX, rt_EX, rs_ID, rt_ID,
               uses_rt_ID, branch_taken_MEM, halt_MEM,
        input  pc_en, enable_ifid, enable_idex, enable_exmem, enable_memwb,
               flush_ifid, flush_idex, flush_exmem, halt, timeout_err,
               stall_cycles, flush_events
    );
endinterface

// File: rtl/hazard_detect.sv
// Load-use hazard detection: ID-stage instruction reads the register an EX-stage load writes.
module hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic     memtoReg_EX_i,
    input  regbits_t rt_EX_i,
    input  regbits_t rs_ID_i,
    input  regbits_t rt_ID_i,
    input  logic     uses_rt_ID_i,
    output logic     luse_o
);
    // $zero is never a real dependency.
    assign luse_o = memtoReg_EX_i && (rt_EX_i != '0) &&
                    ((rt_EX_i == rs_ID_i) || (uses_rt_ID_i && (rt_EX_i == rt_ID_i)));
endmodule

// File: rtl/pipeline_controller.sv
// Hazard and sequencing unit for the 5-stage pipeline: latch enables/flushes, PC write,
// halt, data-memory timeout and stall/flush statistics.
module pipeline_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W        = DEFAULT_CNT_W,
    parameter int DMEM_TIMEOUT = DEFAULT_DMEM_TIMEOUT
)(
    input  logic                  CLK,
    input  logic                  nRST,
    pipeline_controller_if.master bus
);
    localparam int TO_W = $clog2(DMEM_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(DMEM_TIMEOUT - 1);

    ctrl_state_t      state_q, state_d;
    logic             halt_q, halt_d;
    logic             terr_q, terr_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    logic  luse;
    logic  dpend;
    logic  stall_hit;
    logic  flush_hit;
    ctrl_t ctrl_run;
    ctrl_t ctrl;

    hazard_detect u_hazard_detect (
        .memtoReg_EX_i (bus.memtoReg_EX),
        .rt_EX_i       (bus.rt_EX),
        .rs_ID_i       (bus.rs_ID),
        .rt_ID_i       (bus.rt_ID),
        .uses_rt_ID_i  (bus.uses_rt_ID),
        .luse_o        (luse)
    );

    assign dpend = (bus.dmemREN_MEM || bus.dmemWEN_MEM) && !bus.dhit;

    // Lower-priority resolution shared by RUN and the DWAIT release cycle.
    always_comb begin
        ctrl_run = CTRL_GO;
        if (bus.branch_taken_MEM) begin
            ctrl_run = CTRL_BRANCH;
        end else if (luse) begin
            ctrl_run = CTRL_LUSE;
        end else if (!bus.ihit) begin
            ctrl_run = CTRL_IMISS;
        end
    end

    always_comb begin
        state_d   = state_q;
        halt_d    = halt_q;
        terr_d    = terr_q;
        to_cnt_d  = to_cnt_q;
        ctrl      = CTRL_IDLE;
        flush_hit = 1'b0;

        unique case (state_q)
            RUN: begin
                if (bus.halt_MEM) begin
                    ctrl    = CTRL_HALT;
                    state_d = HALTED;
                    halt_d  = 1'b1;
                end else if (dpend) begin
                    ctrl    = CTRL_IDLE;
                    state_d = DWAIT;
                end else begin
                    ctrl      = ctrl_run;
                    flush_hit = bus.branch_taken_MEM;
                end
            end
            DWAIT: begin
                if (!bus.dhit) begin
                    ctrl = CTRL_IDLE;
                    if (to_cnt_q == TO_LAST) begin
                        terr_d = 1'b1;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end else begin
                    ctrl      = ctrl_run;
                    flush_hit = bus.branch_taken_MEM;
                    state_d   = RUN;
                    to_cnt_d  = '0;
                end
            end
            HALTED: begin
                ctrl = CTRL_IDLE;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        // Outputs must be quiet throughout reset, not just after the next edge.
        if (!nRST) begin
            ctrl = CTRL_IDLE;
        end
    end

    assign stall_hit = !ctrl.pc_en && (state_q != HALTED);
    assign stall_d   = (stall_hit && (stall_q != '1)) ? stall_q + 1'b1 : stall_q;
    assign flush_d   = (flush_hit && (flush_q != '1)) ? flush_q + 1'b1 : flush_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= RUN;
            halt_q   <= 1'b0;
            terr_q   <= 1'b0;
            to_cnt_q <= '0;
            stall_q  <= '0;
            flush_q  <= '0;
        end else begin
            state_q  <= state_d;
            halt_q   <= halt_d;
            terr_q   <= terr_d;
            to_cnt_q <= to_cnt_d;
            stall_q  <= stall_d;
            flush_q  <= flush_d;
        end
    end

    assign bus.pc_en        = ctrl.pc_en;
    assign bus.enable_ifid  = ctrl.en_ifid;
    assign bus.enable_idex  = ctrl.en_idex;
    assign bus.enable_exmem = ctrl.en_exmem;
    assign bus.enable_memwb = ctrl.en_memwb;
    assign bus.flush_ifid   = ctrl.fl_ifid;
    assign bus.flush_idex   = ctrl.fl_idex;
    assign bus.flush_exmem  = ctrl.fl_exmem;
    assign bus.halt         = halt_q;
    assign bus.timeout_err  = terr_q;
    assign bus.stall_cycles = stall_q;
    assign bus.flush_events = flush_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench: combinational priority table plus hand-written DWAIT/halt/timeout/reset sequences.
module tb_pipeline_controller;
    import pipeline_ctrl_pkg::*;

    localparam int CNT_W = 16;
    localparam int TMO   = 8;

    logic CLK;
    logic nRST;
    int   checks;
    int   errors;
    int   exp_stall;
    int   exp_flush;

    pipeline_controller_if #(.CNT_W(CNT_W)) bus_if ();

    pipeline_controller #(.CNT_W(CNT_W), .DMEM_TIMEOUT(TMO)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus_if.master)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       ihit;
        logic       dhit;
        logic       ren;
        logic       wen;
        logic       m2r;
        logic [4:0] rt_ex;
        logic [4:0] rs_id;
        logic [4:0] rt_id;
        logic       use_rt;
        logic       br;
        logic [7:0] exp_ctrl;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    function automatic logic [7:0] get_ctrl();
        return {bus_if.pc_en, bus_if.enable_ifid, bus_if.enable_idex, bus_if.enable_exmem,
                bus_if.enable_memwb, bus_if.flush_ifid, bus_if.flush_idex, bus_if.flush_exmem};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        bus_if.ihit             = 1'b1;
        bus_if.dhit             = 1'b0;
        bus_if.dmemREN_MEM      = 1'b0;
        bus_if.dmemWEN_MEM      = 1'b0;
        bus_if.memtoReg_EX      = 1'b0;
        bus_if.rt_EX            = '0;
        bus_if.rs_ID            = '0;
        bus_if.rt_ID            = '0;
        bus_if.uses_rt_ID       = 1'b0;
        bus_if.branch_taken_MEM = 1'b0;
        bus_if.halt_MEM         = 1'b0;
    endtask

    task automatic reset_pulse();
        nRST = 1'b0;
        #1;
        chk("rst_state", 32'(dut.state_q), 32'(RUN));
        chk("rst_halt", 32'(bus_if.halt), 32'd0);
        chk("rst_terr", 32'(bus_if.timeout_err), 32'd0);
        chk("rst_stall", 32'(bus_if.stall_cycles), 32'd0);
        chk("rst_flush", 32'(bus_if.flush_events), 32'd0);
        chk("rst_ctrl", 32'(get_ctrl()), 32'(CTRL_IDLE));
        @(negedge CLK);
        nRST = 1'b1;
        exp_stall = 0;
        exp_flush = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        exp_stall = 0;
        exp_flush = 0;
        nRST = 1'b0;
        clear_inputs();

        //            ihit dhit ren wen m2r rt_ex  rs_id  rt_id  use br  expected
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, CTRL_GO};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, CTRL_IMISS};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 5'd8, 5'd1, 1'b0, 1'b0, CTRL_LUSE};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 5'd3, 5'd9, 1'b1, 1'b0, CTRL_LUSE};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 5'd3, 5'd9, 1'b0, 1'b0, CTRL_GO};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, CTRL_GO};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd8, 5'd8, 5'd8, 1'b1, 1'b0, CTRL_GO};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, CTRL_BRANCH};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, CTRL_BRANCH};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, CTRL_LUSE};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, CTRL_GO};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 5'd2, 5'd7, 1'b1, 1'b0, CTRL_LUSE};

        // Reset state
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        reset_pulse();

        // Hazard-free fetch
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("idle_ctrl", 32'(get_ctrl()), 32'(CTRL_GO));
            $display("idle cycle %0d ctrl=%b", i, get_ctrl());
            @(negedge CLK);
        end
        chk("idle_stall", 32'(bus_if.stall_cycles), 32'd0);

        // Priority table (all vectors keep the controller in RUN)
        for (int i = 0; i < NV; i++) begin
            bus_if.ihit             = vecs[i].ihit;
            bus_if.dhit             = vecs[i].dhit;
            bus_if.dmemREN_MEM      = vecs[i].ren;
            bus_if.dmemWEN_MEM      = vecs[i].wen;
            bus_if.memtoReg_EX      = vecs[i].m2r;
            bus_if.rt_EX            = vecs[i].rt_ex;
            bus_if.rs_ID            = vecs[i].rs_id;
            bus_if.rt_ID            = vecs[i].rt_id;
            bus_if.uses_rt_ID       = vecs[i].use_rt;
            bus_if.branch_taken_MEM = vecs[i].br;
            #1;
            chk($sformatf("vec%0d_ctrl", i), 32'(get_ctrl()), 32'(vecs[i].exp_ctrl));
            $display("vec %0d ctrl=%b exp=%b", i, get_ctrl(), vecs[i].exp_ctrl);
            if (!vecs[i].exp_ctrl[7]) exp_stall++;
            if (vecs[i].br) exp_flush++;
            @(negedge CLK);
        end
        clear_inputs();
        #1;
        chk("tbl_stall", 32'(bus_if.stall_cycles), 32'(exp_stall));
        chk("tbl_flush", 32'(bus_if.flush_events), 32'(exp_flush));
        @(negedge CLK);

        // Data-cache wait: three frozen cycles then release
        bus_if.dmemREN_MEM = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("dw_ctrl", 32'(get_ctrl()), 32'(CTRL_IDLE));
            chk("dw_state", 32'(dut.state_q), (i == 0) ? 32'(RUN) : 32'(DWAIT));
            $display("dwait cycle %0d state=%0d ctrl=%b", i, dut.state_q, get_ctrl());
            exp_stall++;
            @(negedge CLK);
        end
        bus_if.dhit = 1'b1;
        #1;
        chk("dw_release_ctrl", 32'(get_ctrl()), 32'(CTRL_GO));
        @(negedge CLK);
        clear_inputs();
        #1;
        chk("dw_back_run", 32'(dut.state_q), 32'(RUN));
        chk("dw_stall", 32'(bus_if.stall_cycles), 32'(exp_stall));
        chk("dw_terr", 32'(bus_if.timeout_err), 32'd0);
        @(negedge CLK);

        // Halt entry and sticky halted state
        bus_if.halt_MEM = 1'b1;
        #1;
        chk("halt_entry_ctrl", 32'(get_ctrl()), 32'(CTRL_HALT));
        exp_stall++;
        @(negedge CLK);
        clear_inputs();
        bus_if.branch_taken_MEM = 1'b1;
        bus_if.ihit = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("halted_halt", 32'(bus_if.halt), 32'd1);
            chk("halted_state", 32'(dut.state_q), 32'(HALTED));
            chk("halted_ctrl", 32'(get_ctrl()), 32'(CTRL_IDLE));
            chk("halted_stall", 32'(bus_if.stall_cycles), 32'(exp_stall));
            chk("halted_flush", 32'(bus_if.flush_events), 32'(exp_flush));
            $display("halted cycle %0d ctrl=%b", i, get_ctrl());
            @(negedge CLK);
        end
        clear_inputs();
        reset_pulse();
        #1;
        chk("post_halt_ctrl", 32'(get_ctrl()), 32'(CTRL_GO));
        @(negedge CLK);

        // Data-memory timeout
        bus_if.dmemWEN_MEM = 1'b1;
        #1;
        chk("to_enter_state", 32'(dut.state_q), 32'(RUN));
        @(negedge CLK);
        for (int k = 1; k <= 10; k++) begin
            #1;
            chk("to_state", 32'(dut.state_q), 32'(DWAIT));
            chk("to_terr", 32'(bus_if.timeout_err), (k > TMO) ? 32'd1 : 32'd0);
            chk("to_ctrl", 32'(get_ctrl()), 32'(CTRL_IDLE));
            $display("timeout wait %0d terr=%0d", k, bus_if.timeout_err);
            @(negedge CLK);
        end
        bus_if.dhit = 1'b1;
        #1;
        chk("to_release_ctrl", 32'(get_ctrl()), 32'(CTRL_GO));
        @(negedge CLK);
        clear_inputs();
        #1;
        chk("to_sticky", 32'(bus_if.timeout_err), 32'd1);
        chk("to_run", 32'(dut.state_q), 32'(RUN));
        @(negedge CLK);
        reset_pulse();

        // Asynchronous reset in the middle of a wait
        bus_if.dmemWEN_MEM = 1'b1;
        repeat (4) @(negedge CLK);
        #1;
        chk("mid_state_dwait", 32'(dut.state_q), 32'(DWAIT));
        #1;
        nRST = 1'b0;
        #1;
        chk("mid_rst_state", 32'(dut.state_q), 32'(RUN));
        chk("mid_rst_terr", 32'(bus_if.timeout_err), 32'd0);
        chk("mid_rst_ctrl", 32'(get_ctrl()), 32'(CTRL_IDLE));
        $display("async reset in dwait state=%0d", dut.state_q);
        @(negedge CLK);
        nRST = 1'b1;
        clear_inputs();
        #1;
        chk("final_ctrl", 32'(get_ctrl()), 32'(CTRL_GO));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_controller.md
Name: pipeline_controller

Overview:
- Central hazard and sequencing unit for the 5-stage MIPS pipeline.
- Drives enable/flush for the IF/ID, ID/EX, EX/MEM and MEM/WB latches, plus the PC write enable.
- Resolves data-cache waits, instruction-fetch misses, load-use hazards, taken branches/jumps and halt.
- Also keeps stall/flush performance counters and a data-memory timeout flag.

Parameters:
CNT_W, 16, width of the stall and flush counters (saturating).
DMEM_TIMEOUT, 1024, consecutive DWAIT cycles before timeout_err sets.

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  reset, asynchronous, active-low
ihit  in  1  instruction fetch for current PC completes this cycle
dhit  in  1  data access of MEM-stage instruction completes this cycle
dmemREN_MEM  in  1  MEM-stage instruction is a load
dmemWEN_MEM  in  1  MEM-stage instruction is a store
memtoReg_EX  in  1  EX-stage instruction is a load
rt_EX  in  5  destination register of EX-stage load
rs_ID  in  5  ID-stage source rs
rt_ID  in  5  ID-stage source rt
uses_rt_ID  in  1  ID-stage instruction reads rt
branch_taken_MEM  in  1  branch/jump resolved taken in MEM
halt_MEM  in  1  halt instruction in MEM
pc_en  out  1  PC register load enable
enable_ifid, enable_idex, enable_exmem, enable_memwb  out  1 each  latch enables
flush_ifid, flush_idex, flush_exmem  out  1 each  latch clear (flush overrides enable in latch)
halt  out  1  sticky, processor halted
timeout_err  out  1  sticky, data access exceeded DMEM_TIMEOUT
stall_cycles  out  CNT_W  cycles with pc_en=0 while not HALTED
flush_events  out  CNT_W  count of branch-flush cycles

Behaviour:
- State register: RUN, DWAIT, HALTED. Reset (nRST low, async) sets:
  - state=RUN, halt=0, timeout_err=0, counters=0, timeout counter=0.
- While nRST low, all enables, flushes and pc_en are 0.
- Control outputs are combinational from state and inputs, and valid in the same cycle. State, counters, halt and timeout_err are registered.
- dpend = (dmemREN_MEM|dmemWEN_MEM) & !dhit.
- luse = memtoReg_EX & rt_EX!=0 & (rt_EX==rs_ID | (uses_rt_ID & rt_EX==rt_ID)).
- Priority in RUN, first match wins:
  1. halt_MEM:
     - enable_memwb=1; flush_ifid=flush_idex=flush_exmem=1; pc_en=0.
     - Next state HALTED; halt<=1.
  2. dpend:
     - All enables, flushes and pc_en are 0 (full freeze).
     - Next state DWAIT.
  3. branch_taken_MEM:
     - All enables=1; pc_en=1; flush_ifid=flush_idex=flush_exmem=1.
     - flush_events++.
  4. luse:
     - pc_en=0, enable_ifid=0 (hold), flush_idex=1 (bubble); enable_exmem=enable_memwb=1.
  5. !ihit:
     - pc_en=0; flush_ifid=1; enable_idex=enable_exmem=enable_memwb=1.
  6. Otherwise: all enables=1, pc_en=1, no flush.
- DWAIT:
  - If !dhit: full freeze; timeout counter++. When the counter reaches DMEM_TIMEOUT-1, timeout_err<=1; the counter holds and the state stays DWAIT.
  - If dhit: evaluate exactly as RUN priorities 3-6 (halt is never in MEM while another access is in MEM). Next state RUN; timeout counter<=0.
- HALTED:
  - All enables and pc_en are 0; flushes are 0.
  - Exit only via reset; halt stays 1.
- stall_cycles increments every cycle pc_en=0 and state!=HALTED, including the halt-entry cycle. It saturates at all-ones, as does flush_events.
- A load in EX with rt_EX=0 never stalls.
- A simultaneous branch and load-use in RUN: the branch wins, and the flush removes the dependent instruction.
- A reset asserted in DWAIT or HALTED returns to RUN immediately and asynchronously.

Decomposition:
- Package pipeline_ctrl_pkg:
  - ctrl_state_t enum {RUN, DWAIT, HALTED}.
  - regbits_t (5-bit register index).
  - Default DMEM_TIMEOUT constant.
- Sub-module hazard_detect: purely combinational luse computation from memtoReg_EX, rt_EX, rs_ID, rt_ID, uses_rt_ID. It is reused later by the forwarding unit.
- All other logic stays in pipeline_controller.

Test Plan:
- Reset, then ihit=1 with no hazards for 5 cycles -> all enables=1, pc_en=1, flushes=0, stall_cycles=0.
- dmemREN_MEM=1, dhit=0 for 3 cycles, then dhit=1 -> freeze for 3 cycles (state DWAIT from cycle 2); release cycle enables=1; stall_cycles=3; timeout_err=0.
- memtoReg_EX=1, rt_EX=8, rs_ID=8 -> pc_en=0, enable_ifid=0, flush_idex=1, enable_exmem=1. Repeat with rt_EX=0 -> no stall.
- branch_taken_MEM=1 together with luse -> flush_ifid/idex/exmem=1, pc_en=1, flush_events=1.
- halt_MEM=1 -> that cycle enable_memwb=1 with the three flushes; next cycle halt=1 and all enables 0. Assert ihit/branch afterwards -> outputs unchanged. Pulse nRST -> RUN, halt=0.
- DMEM_TIMEOUT=8, dmemWEN_MEM=1, dhit=0 held for 10 cycles -> timeout_err=1 after the 8th DWAIT cycle and stays sticky after dhit. Assert nRST mid-wait in a second run -> state RUN, timeout_err=0.
